// File: rtl/cam_pkg.sv
// Shared definitions for the camera line-capture path.
// Buffer constants match the Avalon controller's memory map.
package cam_pkg;

    localparam int CAM_WIDTH     = 640;
    localparam int CAM_BUF0_BASE = 0;
    localparam int CAM_BUF1_BASE = 640;

    typedef logic [1:0] cam_state_t;

    localparam cam_state_t ST_IDLE       = 2'd0;
    localparam cam_state_t ST_WAIT_FRAME = 2'd1;
    localparam cam_state_t ST_ACTIVE     = 2'd2;
    localparam cam_state_t ST_DROP       = 2'd3;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer with a third stage and registered edge strobes.
// level, rise and fall are mutually aligned.
module cam_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] s3_q;
    logic [W-1:0] rise_d;
    logic [W-1:0] rise_q;
    logic [W-1:0] fall_d;
    logic [W-1:0] fall_q;

    always_comb begin
        rise_d = s2_q & ~s3_q;
        fall_d = ~s2_q & s3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = s3_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/cam_line_capture.sv
// Camera bus capture into ping-pong line buffers with an
// ownership handshake toward the Avalon-side consumer.
module cam_line_capture
    import cam_pkg::*;
#(
    parameter int WIDTH     = CAM_WIDTH,
    parameter int BUF0_BASE = CAM_BUF0_BASE,
    parameter int BUF1_BASE = CAM_BUF1_BASE,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cam_pclk,
    input  logic              cam_hsync,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    output logic              buf_write,
    output logic [ADDR_W-1:0] buf_address,
    output logic [15:0]       buf_writedata,
    output logic              line_ready,
    output logic              line_buf,
    input  logic              line_ack,
    input  logic              ack_buf,
    output logic [1:0]        buf_full,
    output logic              frame_start,
    output logic [9:0]        line_count,
    output logic [15:0]       frame_count,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BUF0_BASE);
    localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BUF1_BASE);
    localparam logic [COL_W-1:0]  COL_END = COL_W'(WIDTH);

    logic [2:0] sy_level;
    logic [2:0] sy_rise;
    logic [2:0] sy_fall;

    cam_sync_edge #(.W(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({cam_vsync, cam_hsync, cam_pclk}),
        .level (sy_level),
        .rise  (sy_rise),
        .fall  (sy_fall)
    );

    logic pclk_rise;
    logic hs_level;
    logic hs_rise;
    logic hs_fall;
    logic vs_level;
    logic vs_rise;
    logic vs_fall;
    logic [1:0] unused_pclk;

    assign pclk_rise   = sy_rise[0];
    assign hs_level    = sy_level[1];
    assign hs_rise     = sy_rise[1];
    assign hs_fall     = sy_fall[1];
    assign vs_level    = sy_level[2];
    assign vs_rise     = sy_rise[2];
    assign vs_fall     = sy_fall[2];
    assign unused_pclk = {sy_level[0], sy_fall[0]};

    // Same depth as the sync path so the byte lines up with pclk_rise.
    logic [7:0] d1_q;
    logic [7:0] d2_q;
    logic [7:0] d3_q;

    cam_state_t        state_q, state_d;
    logic              cur_q, cur_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              act_q, act_d;
    logic              buf_write_q, buf_write_d;
    logic [ADDR_W-1:0] buf_address_q, buf_address_d;
    logic [15:0]       buf_writedata_q, buf_writedata_d;
    logic              line_ready_q, line_ready_d;
    logic              line_buf_q, line_buf_d;
    logic [1:0]        buf_full_q, buf_full_d;
    logic              frame_start_q, frame_start_d;
    logic [9:0]        line_count_q, line_count_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              overflow_q, overflow_d;
    logic              handoff;
    logic              drop;

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        col_d           = col_q;
        phase_d         = phase_q;
        hi_d            = hi_q;
        act_d           = act_q;
        buf_write_d     = 1'b0;
        buf_address_d   = buf_address_q;
        buf_writedata_d = buf_writedata_q;
        line_ready_d    = 1'b0;
        line_buf_d      = line_buf_q;
        frame_start_d   = 1'b0;
        line_count_d    = line_count_q;
        frame_count_d   = frame_count_q;
        handoff         = 1'b0;
        drop            = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            act_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_FRAME;
                ST_WAIT_FRAME: begin
                    if (vs_fall) begin
                        state_d       = ST_ACTIVE;
                        act_d         = 1'b0;
                        frame_start_d = 1'b1;
                        line_count_d  = '0;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        state_d = ST_WAIT_FRAME;
                        act_d   = 1'b0;
                    end else if (hs_rise) begin
                        col_d   = '0;
                        phase_d = 1'b0;
                        if (buf_full_q[cur_q]) begin
                            state_d = ST_DROP;
                            act_d   = 1'b0;
                            drop    = 1'b1;
                        end else begin
                            act_d = 1'b1;
                        end
                    end else if (hs_fall) begin
                        act_d = 1'b0;
                        if (act_q && col_q != '0) begin
                            handoff      = 1'b1;
                            line_ready_d = 1'b1;
                            line_buf_d   = cur_q;
                            cur_d        = ~cur_q;
                            if (line_count_q != '1)
                                line_count_d = line_count_q + 10'd1;
                        end
                    end else if (act_q && hs_level && !vs_level &&
                                 pclk_rise && col_q != COL_END) begin
                        if (!phase_q) begin
                            hi_d    = d3_q;
                            phase_d = 1'b1;
                        end else begin
                            buf_write_d     = 1'b1;
                            buf_address_d   = (cur_q ? B1 : B0) +
                                              ADDR_W'(col_q);
                            buf_writedata_d = {hi_q, d3_q};
                            col_d           = col_q + 1'b1;
                            phase_d         = 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (vs_rise)
                        state_d = ST_WAIT_FRAME;
                    else if (hs_fall)
                        state_d = ST_ACTIVE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Ack and handoff never target the same bit, so both can apply.
        buf_full_d = buf_full_q;
        if (line_ack)
            buf_full_d[ack_buf] = 1'b0;
        if (handoff)
            buf_full_d[cur_q] = 1'b1;

        overflow_d = overflow_q;
        if (clear_overflow)
            overflow_d = 1'b0;
        if (drop)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_q            <= '0;
            d2_q            <= '0;
            d3_q            <= '0;
            state_q         <= ST_IDLE;
            cur_q           <= 1'b0;
            col_q           <= '0;
            phase_q         <= 1'b0;
            hi_q            <= '0;
            act_q           <= 1'b0;
            buf_write_q     <= 1'b0;
            buf_address_q   <= '0;
            buf_writedata_q <= '0;
            line_ready_q    <= 1'b0;
            line_buf_q      <= 1'b0;
            buf_full_q      <= '0;
            frame_start_q   <= 1'b0;
            line_count_q    <= '0;
            frame_count_q   <= '0;
            overflow_q      <= 1'b0;
        end else begin
            d1_q            <= cam_data;
            d2_q            <= d1_q;
            d3_q            <= d2_q;
            state_q         <= state_d;
            cur_q           <= cur_d;
            col_q           <= col_d;
            phase_q         <= phase_d;
            hi_q            <= hi_d;
            act_q           <= act_d;
            buf_write_q     <= buf_write_d;
            buf_address_q   <= buf_address_d;
            buf_writedata_q <= buf_writedata_d;
            line_ready_q    <= line_ready_d;
            line_buf_q      <= line_buf_d;
            buf_full_q      <= buf_full_d;
            frame_start_q   <= frame_start_d;
            line_count_q    <= line_count_d;
            frame_count_q   <= frame_count_d;
            overflow_q      <= overflow_d;
        end
    end

    assign buf_write     = buf_write_q;
    assign buf_address   = buf_address_q;
    assign buf_writedata = buf_writedata_q;
    assign line_ready    = line_ready_q;
    assign line_buf      = line_buf_q;
    assign buf_full      = buf_full_q;
    assign frame_start   = frame_start_q;
    assign line_count    = line_count_q;
    assign frame_count   = frame_count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_cam_line_capture.sv
// Scoreboard bench for cam_line_capture: expected writes and
// handoffs are queued with the stimulus and popped on DUT output.
module tb_cam_line_capture;
    import cam_pkg::*;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cam_pclk;
    logic        cam_hsync;
    logic        cam_vsync;
    logic [7:0]  cam_data;
    logic        buf_write;
    logic [10:0] buf_address;
    logic [15:0] buf_writedata;
    logic        line_ready;
    logic        line_buf;
    logic        line_ack;
    logic        ack_buf;
    logic [1:0]  buf_full;
    logic        frame_start;
    logic [9:0]  line_count;
    logic [15:0] frame_count;
    logic        overflow;
    logic        clear_overflow;

    cam_line_capture dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .cam_pclk       (cam_pclk),
        .cam_hsync      (cam_hsync),
        .cam_vsync      (cam_vsync),
        .cam_data       (cam_data),
        .buf_write      (buf_write),
        .buf_address    (buf_address),
        .buf_writedata  (buf_writedata),
        .line_ready     (line_ready),
        .line_buf       (line_buf),
        .line_ack       (line_ack),
        .ack_buf        (ack_buf),
        .buf_full       (buf_full),
        .frame_start    (frame_start),
        .line_count     (line_count),
        .frame_count    (frame_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int fs_cnt;
    logic [26:0] wr_q[$];
    logic        rdy_q[$];

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (buf_write) begin
                check("wr_pending", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    logic [26:0] e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(buf_address), 32'(e[26:16]));
                    check("wr_data", 32'(buf_writedata), 32'(e[15:0]));
                end
            end
            if (line_ready) begin
                check("rdy_pending", 32'(rdy_q.size() != 0), 1);
                if (rdy_q.size() != 0) begin
                    logic eb;
                    eb = rdy_q.pop_front();
                    check("rdy_buf", 32'(line_buf), 32'(eb));
                end
            end
            if (frame_start)
                fs_cnt++;
        end
    end

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        wait_clk(2);
        cam_pclk = 1'b1;
        wait_clk(2);
    endtask

    task automatic send_bytes(int first, int n);
        for (int i = first; i < first + n; i++)
            send_byte(8'(i));
    endtask

    task automatic send_line(int nbytes);
        cam_hsync = 1'b1;
        wait_clk(4);
        send_bytes(0, nbytes);
        cam_pclk = 1'b0;
        wait_clk(4);
        cam_hsync = 1'b0;
        wait_clk(8);
    endtask

    task automatic expect_line(int nbytes, logic cur, logic handoff);
        int base;
        base = cur ? CAM_BUF1_BASE : CAM_BUF0_BASE;
        for (int k = 0; k < nbytes / 2 && k < CAM_WIDTH; k++)
            wr_q.push_back({11'(base + k), 8'(2 * k), 8'(2 * k + 1)});
        if (handoff)
            rdy_q.push_back(cur);
    endtask

    task automatic drain(string tag);
        check({tag, "_wr_left"}, 32'(wr_q.size()), 0);
        check({tag, "_rdy_left"}, 32'(rdy_q.size()), 0);
    endtask

    task automatic pulse_ack(logic b);
        line_ack = 1'b1;
        ack_buf  = b;
        wait_clk(1);
        line_ack = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        fs_cnt = 0;
        reset = 1'b1;
        enable = 1'b0;
        cam_pclk = 1'b0;
        cam_hsync = 1'b0;
        cam_vsync = 1'b1;
        cam_data = 8'h00;
        line_ack = 1'b0;
        ack_buf = 1'b0;
        clear_overflow = 1'b0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);

        check("rst_write", 32'(buf_write), 0);
        check("rst_addr", 32'(buf_address), 0);
        check("rst_wdata", 32'(buf_writedata), 0);
        check("rst_ready", 32'({line_ready, line_buf}), 0);
        check("rst_full", 32'(buf_full), 0);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_lines", 32'(line_count), 0);
        check("rst_frames", 32'(frame_count), 0);
        check("rst_ovf", 32'(overflow), 0);

        enable = 1'b1;
        wait_clk(6);
        cam_vsync = 1'b0;
        wait_clk(8);
        check("f1_fs", 32'(fs_cnt), 1);
        check("f1_frames", 32'(frame_count), 1);

        expect_line(1280, 1'b0, 1'b1);
        send_line(1280);
        drain("l0");
        expect_line(1280, 1'b1, 1'b1);
        send_line(1280);
        drain("l1");
        check("l1_full", 32'(buf_full), 2'b11);
        check("l1_lines", 32'(line_count), 2);
        check("l1_frames", 32'(frame_count), 1);

        send_line(40);
        drain("drop");
        check("drop_ovf", 32'(overflow), 1);
        check("drop_lines", 32'(line_count), 2);
        check("drop_full", 32'(buf_full), 2'b11);

        pulse_ack(1'b0);
        check("ack0_full", 32'(buf_full), 2'b10);
        expect_line(1280, 1'b0, 1'b1);
        send_line(1280);
        drain("l3");
        check("l3_full", 32'(buf_full), 2'b11);
        check("l3_lines", 32'(line_count), 3);

        pulse_ack(1'b1);
        check("ack1_full", 32'(buf_full), 2'b01);
        expect_line(1400, 1'b1, 1'b1);
        send_line(1400);
        drain("long");
        check("long_lines", 32'(line_count), 4);

        pulse_ack(1'b0);
        pulse_ack(1'b1);
        check("ack01_full", 32'(buf_full), 2'b00);
        expect_line(3, 1'b0, 1'b1);
        send_line(3);
        drain("odd");
        check("odd_full", 32'(buf_full), 2'b01);
        check("odd_lines", 32'(line_count), 5);

        expect_line(200, 1'b1, 1'b0);
        cam_hsync = 1'b1;
        wait_clk(4);
        send_bytes(0, 200);
        cam_pclk = 1'b0;
        wait_clk(6);
        cam_vsync = 1'b1;
        wait_clk(6);
        cam_hsync = 1'b0;
        wait_clk(10);
        drain("vsmid");
        check("vsmid_state", 32'(dut.state_q), 32'(ST_WAIT_FRAME));
        check("vsmid_full", 32'(buf_full), 2'b01);
        check("vsmid_lines", 32'(line_count), 5);
        cam_vsync = 1'b0;
        wait_clk(8);
        check("f2_fs", 32'(fs_cnt), 2);
        check("f2_lines", 32'(line_count), 0);
        check("f2_frames", 32'(frame_count), 2);

        expect_line(20, 1'b1, 1'b1);
        cam_hsync = 1'b1;
        wait_clk(4);
        send_bytes(0, 20);
        cam_pclk = 1'b0;
        wait_clk(4);
        cam_hsync = 1'b0;
        wait_clk(3);
        check("rdy_early", 32'(line_ready), 0);
        line_ack = 1'b1;
        ack_buf = 1'b0;
        wait_clk(1);
        line_ack = 1'b0;
        check("rdy_lat", 32'(line_ready), 1);
        check("same_full", 32'(buf_full), 2'b10);
        wait_clk(6);
        drain("same");

        check("ovf_before", 32'(overflow), 1);
        clear_overflow = 1'b1;
        wait_clk(1);
        clear_overflow = 1'b0;
        wait_clk(1);
        check("ovf_clr", 32'(overflow), 0);

        expect_line(20, 1'b0, 1'b1);
        send_line(20);
        drain("l8");
        check("l8_full", 32'(buf_full), 2'b11);
        cam_hsync = 1'b1;
        wait_clk(3);
        clear_overflow = 1'b1;
        wait_clk(1);
        clear_overflow = 1'b0;
        check("ovf_setwins", 32'(overflow), 1);
        send_bytes(0, 20);
        cam_pclk = 1'b0;
        wait_clk(4);
        cam_hsync = 1'b0;
        wait_clk(8);
        drain("drop2");
        check("drop2_lines", 32'(line_count), 2);

        pulse_ack(1'b0);
        pulse_ack(1'b1);
        expect_line(100, 1'b1, 1'b0);
        cam_hsync = 1'b1;
        wait_clk(4);
        send_bytes(0, 100);
        cam_pclk = 1'b0;
        wait_clk(8);
        enable = 1'b0;
        wait_clk(2);
        check("dis_state", 32'(dut.state_q), 32'(ST_IDLE));
        send_bytes(100, 40);
        cam_pclk = 1'b0;
        wait_clk(4);
        cam_hsync = 1'b0;
        wait_clk(8);
        drain("dis");
        check("dis_full", 32'(buf_full), 2'b00);

        enable = 1'b1;
        wait_clk(4);
        check("ren_state", 32'(dut.state_q), 32'(ST_WAIT_FRAME));
        send_line(40);
        drain("ren_wait");
        cam_vsync = 1'b1;
        wait_clk(8);
        cam_vsync = 1'b0;
        wait_clk(8);
        check("f3_fs", 32'(fs_cnt), 3);
        check("f3_frames", 32'(frame_count), 3);
        check("f3_lines", 32'(line_count), 0);
        expect_line(20, 1'b1, 1'b1);
        send_line(20);
        drain("resume");
        check("resume_full", 32'(buf_full), 2'b10);
        check("resume_lines", 32'(line_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
